// File: rtl/led_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// led_sequencer_pkg
// Shared constants for the LED sequencer and anything that drives or checks it:
//   MODE_*     : encodings of the 2-bit mode input
//   dir_e      : bounce direction (LEFT = towards bit N-1, RIGHT = towards bit 0)
//   is_onehot  : one-hot test on a zero-extended 16-bit value (N is at most 16)
// -----------------------------------------------------------------------------
package led_sequencer_pkg;

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_ROT    = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;

    // Widest legal pattern; narrower patterns are zero-extended to this width.
    localparam int MAX_W = 16;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    function automatic logic is_onehot(input logic [MAX_W-1:0] v);
        return (v != '0) && ((v & (v - 16'd1)) == '0);
    endfunction

endpackage

// File: rtl/led_sequencer_edge_detect.sv
// -----------------------------------------------------------------------------
// edge_detect
// Rising-edge detector for a level that is already synchronous to clk.
// Ports:
//   clk    : clock
//   rstn   : synchronous active-low reset; loads sig_q with RESET_VAL
//   sig_in : level to watch
//   sig_q  : sig_in delayed by one clk (tracked every cycle)
//   rise   : combinational, sig_in high while sig_q low
// RESET_VAL defaults to 1 so a level that is already high when reset is
// released is not mistaken for a fresh rising edge.
// -----------------------------------------------------------------------------
module edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic sig_in,
    output logic sig_q,
    output logic rise
);

    logic sig_d;

    always_comb begin
        sig_d = sig_in;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sig_q <= RESET_VAL;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign rise = sig_in & ~sig_q;

endmodule

// File: rtl/led_sequencer.sv
// -----------------------------------------------------------------------------
// led_sequencer
// Advances an N-bit LED pattern once per rising edge of tick_in while ena is
// high. Patterns: up counter, down counter, rotate-left, and a bouncing dot.
// Ports:
//   clk     : clock, rising edge
//   rstn    : synchronous active-low reset
//   tick_in : slow tick (e.g. prescaler clk_out), synchronous to clk
//   ena     : step enable
//   mode    : pattern select (MODE_UP / MODE_DOWN / MODE_ROT / MODE_BOUNCE)
//   leds    : current pattern, registered
//   step    : one-clk pulse on every advance
//   wrap    : one-clk pulse when a sequence wraps or the bounce reverses
// -----------------------------------------------------------------------------
module led_sequencer
    import led_sequencer_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         tick_in,
    input  logic         ena,
    input  logic [1:0]   mode,
    output logic [N-1:0] leds,
    output logic         step,
    output logic         wrap
);

    localparam logic [N-1:0] ONE = N'(1);

    logic         tick_q;
    logic         rise;
    logic         do_step;

    logic [N-1:0] leds_q, leds_d;
    logic         step_q, step_d;
    logic         wrap_q, wrap_d;
    logic [1:0]   mode_q, mode_d;
    dir_e         dir_q,  dir_d;

    logic [MAX_W-1:0] leds_ext;
    logic             legal;

    edge_detect #(
        .RESET_VAL (1'b1)
    ) u_edge (
        .clk    (clk),
        .rstn   (rstn),
        .sig_in (tick_in),
        .sig_q  (tick_q),
        .rise   (rise)
    );

    // tick_q keeps tracking while ena is low, so enabling during a high tick
    // does not create a step.
    assign do_step = rise & ena;

    // Zero-extend the pattern to the package helper's fixed width.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_W; gi++) begin : g_ext
            if (gi < N) begin : g_bit
                assign leds_ext[gi] = leds_q[gi];
            end else begin : g_pad
                assign leds_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign legal = is_onehot(leds_ext);

    always_comb begin
        leds_d = leds_q;
        step_d = 1'b0;
        wrap_d = 1'b0;
        mode_d = mode_q;
        dir_d  = dir_q;

        if (do_step) begin
            step_d = 1'b1;
            mode_d = mode;
            if (mode != mode_q) begin
                // New mode: restart from its start pattern, never a wrap.
                dir_d = DIR_LEFT;
                case (mode)
                    MODE_UP:   leds_d = '0;
                    MODE_DOWN: leds_d = '1;
                    default:   leds_d = ONE;
                endcase
            end else begin
                case (mode_q)
                    MODE_UP: begin
                        leds_d = leds_q + ONE;
                        wrap_d = (leds_q == '1);
                    end
                    MODE_DOWN: begin
                        leds_d = leds_q - ONE;
                        wrap_d = (leds_q == '0);
                    end
                    MODE_ROT: begin
                        if (!legal) begin
                            leds_d = ONE;
                        end else begin
                            leds_d = {leds_q[N-2:0], leds_q[N-1]};
                            wrap_d = leds_q[N-1];
                        end
                    end
                    default: begin
                        // Bounce: the dot turns round on the step that lands
                        // on an end bit, and that step carries the wrap pulse.
                        if (!legal) begin
                            leds_d = ONE;
                            dir_d  = DIR_LEFT;
                        end else if (dir_q == DIR_LEFT) begin
                            leds_d = leds_q << 1;
                            if (leds_d[N-1]) begin
                                dir_d  = DIR_RIGHT;
                                wrap_d = 1'b1;
                            end
                        end else begin
                            leds_d = leds_q >> 1;
                            if (leds_d[0]) begin
                                dir_d  = DIR_LEFT;
                                wrap_d = 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            leds_q <= '0;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
            mode_q <= MODE_UP;
            dir_q  <= DIR_LEFT;
        end else begin
            leds_q <= leds_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
            mode_q <= mode_d;
            dir_q  <= dir_d;
        end
    end

    assign leds = leds_q;
    assign step = step_q;
    assign wrap = wrap_q;

endmodule
